tile_ram: RTL
=============

Name: tile_ram

Overview:
Dual-port tile memory for the playfield grid (COLS x ROWS cells, DATA_WIDTH bits per cell). Port A is read/write for game logic; port B is read-only for the video scan-out.
A built-in init engine rewrites the whole grid with the arena pattern:
- border cells get BORDER_VAL;
- all other cells get EMPTY_VAL.
The engine runs after reset and on request, replacing the static initial-block preload.

Parameters:
DATA_WIDTH, 3, bits per cell
COLS, 80, grid width in cells
ROWS, 60, grid height in cells
ADDR_WIDTH, 13, address bits; must satisfy 2^ADDR_WIDTH >= COLS*ROWS
EMPTY_VAL, 0, value written to interior cells
BORDER_VAL, 4, value written to row 0, row ROWS-1, col 0 and col COLS-1
RDW_MODE, 0, port B read of an address port A writes in the same cycle: 0 = old data, 1 = new data
INIT_ON_RESET, 1, 1 = init engine starts automatically after reset release

Ports:
i_clk  in  1  clock; all logic on the rising edge
i_rstn  in  1  synchronous, active-low reset
i_clear  in  1  one-cycle pulse; requests a grid re-init
o_busy  out  1  high while the init engine owns the memory
o_done  out  1  one-cycle pulse on the last init write
i_a_addr  in  ADDR_WIDTH  port A address (row*COLS+col)
i_a_write  in  1  port A write enable
i_a_data  in  DATA_WIDTH  port A write data
o_a_data  out  DATA_WIDTH  port A read data
i_b_addr  in  ADDR_WIDTH  port B address
o_b_data  out  DATA_WIDTH  port B read data

Behaviour:
- Memory array is DEPTH = COLS*ROWS words. Its contents are not cleared by reset; only the engine or port A writes change them.
- Reset (i_rstn=0 at an edge):
  - o_a_data=0, o_b_data=0, o_busy=0, o_done=0;
  - FSM forced to IDLE; col, row and address counters = 0.
- Port A:
  - i_a_write=1: mem[i_a_addr] <= i_a_data, and o_a_data holds its previous value.
  - i_a_write=0: o_a_data <= mem[i_a_addr], 1-cycle latency.
- Port B: o_b_data <= mem[i_b_addr] every cycle, 1-cycle latency, never blocked, including while busy.
- Port A write while port B reads the same address in the same cycle:
  - RDW_MODE=0: o_b_data gets the old data;
  - RDW_MODE=1: o_b_data gets i_a_data.
- Addresses >= DEPTH:
  - writes are dropped;
  - reads return 0.
- FSM states: IDLE, INIT.
  - IDLE -> INIT on the first cycle after reset release if INIT_ON_RESET=1. o_busy=1 from the following cycle.
  - IDLE -> INIT on i_clear=1. o_busy=1 the next cycle.
  - INIT writes exactly one cell per cycle in raster order, addr 0..DEPTH-1.
  - Counters: col wraps at COLS-1 to 0 and increments row. addr increments by 1, with no multiplier.
  - Value written is BORDER_VAL if row==0, row==ROWS-1, col==0 or col==COLS-1; otherwise EMPTY_VAL.
  - INIT -> IDLE after writing addr DEPTH-1. o_done=1 in the cycle that write is issued; o_busy=0 the next cycle.
  - Total INIT duration is DEPTH cycles.
- While o_busy=1:
  - port A writes are ignored;
  - port A reads still return memory contents, which may be partially initialised.
- i_clear during INIT is ignored: the engine does not restart or extend.
- i_clear in the same cycle the last INIT write is issued is ignored.
- Reset asserted mid-INIT aborts the engine; the grid is left partially written. With INIT_ON_RESET=1 the engine restarts from addr 0 after reset release.

Decomposition:
- Shared package tile_pkg holds:
  - cell-code constants (EMPTY=0, FOOD=5, BORDER=4, SNAKE);
  - default grid dimensions COLS=80, ROWS=60;
  - the ADDR_WIDTH calculation.
- One natural sub-module, tile_init_fsm: IDLE/INIT FSM, col/row/addr counters, border decode. It outputs wr_en, wr_addr, wr_data, busy and done.
- tile_ram muxes the engine's write port over port A.

Test Plan:
1. COLS=4, ROWS=3, INIT_ON_RESET=1; reset 2 cycles then release.
   - o_busy rises within 2 cycles and stays high for exactly 12 cycles; o_done pulses once.
   - Port B dump gives 4,4,4,4 / 4,0,0,4 / 4,4,4,4.
2. After init, port A writes 5 to addr 5, then reads addr 5.
   - o_a_data=5 one cycle after the read cycle.
   - o_a_data is unchanged during the write cycle.
3. Port A writes 7 to addr 6 while port B reads addr 6 in the same cycle.
   - RDW_MODE=0: o_b_data=0.
   - RDW_MODE=1: o_b_data=7.
   - Next cycle, either mode: o_b_data=7.
4. Pulse i_clear, then attempt a port A write of 3 to addr 5 while busy; pulse i_clear again at cycle 6 of INIT.
   - Write is dropped; o_busy stays high exactly 12 cycles total.
   - After completion, addr 5 reads 0.
5. Assert reset at INIT cycle 5 for 1 cycle.
   - Outputs go 0; engine restarts at addr 0 and completes 12 cycles later.
   - Final grid matches scenario 1.
6. INIT_ON_RESET=0; release reset.
   - o_busy stays 0 for 20 cycles.
   - Port A write/read of addr 11 works immediately.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared tile codes, default grid dimensions and address sizing.
// Imported by the tile memory and its init engine.
package tile_pkg;

  localparam int EMPTY  = 0;
  localparam int SNAKE  = 1;
  localparam int BORDER = 4;
  localparam int FOOD   = 5;

  localparam int GRID_COLS = 80;
  localparam int GRID_ROWS = 60;

  function automatic int addr_bits(
    input int cols,
    input int rows
  );
    return (cols * rows > 1) ? $clog2(cols * rows) : 1;
  endfunction

  localparam int ADDR_W_DEF = addr_bits(GRID_COLS, GRID_ROWS);

  typedef enum logic {
    IDLE,
    INIT
  } init_state_t;

endpackage

// File: rtl/tile_init_fsm.sv
// Arena init engine: walks the grid in raster order, one write per cycle.
// Ports: i_clk, i_rstn, i_clear in; wr_en/wr_addr/wr_data, busy, done out.
module tile_init_fsm
  import tile_pkg::*;
#(
  parameter int DATA_WIDTH = 3,
  parameter int COLS       = GRID_COLS,
  parameter int ROWS       = GRID_ROWS,
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter logic [DATA_WIDTH-1:0] EMPTY_VAL  = DATA_WIDTH'(EMPTY),
  parameter logic [DATA_WIDTH-1:0] BORDER_VAL = DATA_WIDTH'(BORDER),
  parameter bit    INIT_ON_RESET = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_clear,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int DEPTH = COLS * ROWS;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST =
    ADDR_WIDTH'(DEPTH - 1);

  init_state_t state, state_n;
  logic          boot;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [ADDR_WIDTH-1:0] addr;
  logic          last;
  logic          edge_cell;

  assign last = (addr == ADDR_LAST);

  // boot marks the first cycle after reset release
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state <= IDLE;
      boot  <= 1'b1;
      col   <= '0;
      row   <= '0;
      addr  <= '0;
    end else begin
      state <= state_n;
      boot  <= 1'b0;
      if (wr_en) begin
        if (last) begin
          col  <= '0;
          row  <= '0;
          addr <= '0;
        end else begin
          addr <= addr + 1'b1;
          if (col == COL_LAST) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    wr_en   = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_clear || (INIT_ON_RESET && boot))
          state_n = INIT;
      end
      INIT: begin
        wr_en = 1'b1;
        if (last) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
    endcase
  end

  assign edge_cell = (row == '0) || (row == ROW_LAST) ||
                     (col == '0) || (col == COL_LAST);

  assign busy    = (state == INIT);
  assign wr_addr = addr;
  assign wr_data = edge_cell ? BORDER_VAL : EMPTY_VAL;

endmodule

// File: rtl/tile_ram.sv
// Dual-port playfield memory: A read/write, B read-only, with init engine.
// Ports: i_clk, i_rstn, i_clear, o_busy, o_done, port A and port B buses.
module tile_ram
  import tile_pkg::*;
#(
  parameter int DATA_WIDTH = 3,
  parameter int COLS       = GRID_COLS,
  parameter int ROWS       = GRID_ROWS,
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter logic [DATA_WIDTH-1:0] EMPTY_VAL  = DATA_WIDTH'(EMPTY),
  parameter logic [DATA_WIDTH-1:0] BORDER_VAL = DATA_WIDTH'(BORDER),
  parameter int    RDW_MODE      = 0,
  parameter bit    INIT_ON_RESET = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_clear,
  output logic                  o_busy,
  output logic                  o_done,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic                  i_a_write,
  input  logic [DATA_WIDTH-1:0] i_a_data,
  output logic [DATA_WIDTH-1:0] o_a_data,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  output logic [DATA_WIDTH-1:0] o_b_data
);

  localparam int DEPTH = COLS * ROWS;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST =
    ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  eng_we;
  logic [ADDR_WIDTH-1:0] eng_addr;
  logic [DATA_WIDTH-1:0] eng_data;
  logic                  a_ok;
  logic                  b_ok;
  logic                  a_we;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  b_hit;

  tile_init_fsm #(
    .DATA_WIDTH    (DATA_WIDTH),
    .COLS          (COLS),
    .ROWS          (ROWS),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .EMPTY_VAL     (EMPTY_VAL),
    .BORDER_VAL    (BORDER_VAL),
    .INIT_ON_RESET (INIT_ON_RESET)
  ) u_init (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_clear (i_clear),
    .wr_en   (eng_we),
    .wr_addr (eng_addr),
    .wr_data (eng_data),
    .busy    (o_busy),
    .done    (o_done)
  );

  assign a_ok = (i_a_addr <= ADDR_LAST);
  assign b_ok = (i_b_addr <= ADDR_LAST);

  // engine owns the write port while busy
  assign a_we  = i_a_write && !o_busy && a_ok;
  assign we    = eng_we || a_we;
  assign waddr = eng_we ? eng_addr : i_a_addr;
  assign wdata = eng_we ? eng_data : i_a_data;
  assign b_hit = (RDW_MODE != 0) && we && (waddr == i_b_addr);

  always_ff @(posedge i_clk) begin
    if (i_rstn && we)
      mem[waddr[IW-1:0]] <= wdata;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_a_data <= '0;
      o_b_data <= '0;
    end else begin
      if (!i_a_write)
        o_a_data <= a_ok ? mem[i_a_addr[IW-1:0]] : '0;
      if (!b_ok)
        o_b_data <= '0;
      else if (b_hit)
        o_b_data <= wdata;
      else
        o_b_data <= mem[i_b_addr[IW-1:0]];
    end
  end

endmodule
